// File: rtl/lock_pkg.sv
// lock_pkg: shared types, status codes and default combination for lock_seq_ctrl
package lock_pkg;
  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd9;
  localparam int DEFAULT_LEN = 6;
  localparam logic [DIGIT_W-1:0] DEFAULT_COMBO [DEFAULT_LEN] = '{4'd8, 4'd7, 4'd5, 4'd8, 4'd2, 4'd8};
  localparam logic [2:0] ST_ENTRY   = 3'd0;
  localparam logic [2:0] ST_OPEN    = 3'd1;
  localparam logic [2:0] ST_FAIL    = 3'd2;
  localparam logic [2:0] ST_LOCKOUT = 3'd3;
  localparam logic [2:0] ST_PROG    = 3'd4;
  // state encodings equal the display codes so status is a plain copy of state
  typedef enum logic [2:0] {
    S_ENTRY   = ST_ENTRY,
    S_OPEN    = ST_OPEN,
    S_FAIL    = ST_FAIL,
    S_LOCKOUT = ST_LOCKOUT,
    S_PROG    = ST_PROG
  } state_t;
  function automatic logic [DIGIT_W-1:0] default_digit(input int i);
    return DEFAULT_COMBO[i % DEFAULT_LEN];
  endfunction
endpackage

// File: rtl/lock_timer.sv
// lock_timer: loadable saturating down-counter shared by lockout and entry timeout
module lock_timer #(
  parameter int W = 10
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_zero,
  output logic         o_last
);
  logic [W-1:0] r_count;
  // load has priority over counting; the count holds at zero
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_count <= '0;
    else if (i_load) r_count <= i_load_val;
    else if (i_en && r_count != '0) r_count <= r_count - 1'b1;
  assign o_zero = (r_count == '0);
  assign o_last = (r_count == W'(1));
endmodule

// File: rtl/lock_seq_ctrl.sv
// lock_seq_ctrl: keypad combination-lock sequencer; LOCK_PROG_EN adds reprogramming from OPEN
module lock_seq_ctrl
  import lock_pkg::*;
#(
  parameter int NUM_DIGITS     = 6,
  parameter int MAX_FAIL       = 3,
  parameter int LOCKOUT_CYCLES = 1000,
  parameter int TIMEOUT_CYCLES = 500
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic [DIGIT_W-1:0]                i_digit,
  input  logic                              i_digit_valid,
  output logic                              o_digit_ready,
  input  logic                              i_relock,
`ifdef LOCK_PROG_EN
  input  logic                              i_prog_req,
`endif
  output logic                              o_open,
  output logic                              o_locked_out,
  output logic [$clog2(MAX_FAIL+1)-1:0]     o_fail_cnt,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   o_pos,
  output logic [2:0]                        o_status
);
  localparam int FW   = $clog2(MAX_FAIL + 1);
  localparam int PW   = $clog2(NUM_DIGITS + 1);
  localparam int TMAX = (LOCKOUT_CYCLES > TIMEOUT_CYCLES) ? LOCKOUT_CYCLES : TIMEOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [PW-1:0] LAST_POS = PW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_FAIL);
  localparam logic [TW-1:0] T_LOCK   = TW'(LOCKOUT_CYCLES);
  localparam logic [TW-1:0] T_IDLE   = TW'(TIMEOUT_CYCLES);
  state_t             r_state, w_state_nxt;
  logic [PW-1:0]      r_pos, w_pos_nxt;
  logic [FW-1:0]      r_fail, w_fail_nxt;
  logic               r_mis, w_mis_nxt;
  logic               w_xfer, w_hit, w_load, w_tmr_en, w_tmr_zero, w_tmr_last, w_expire;
  logic [TW-1:0]      w_load_val;
  logic [DIGIT_W-1:0] w_combo [NUM_DIGITS];
  assign w_xfer   = i_digit_valid & o_digit_ready;
  assign w_hit    = (i_digit == w_combo[r_pos]) && (i_digit <= MAX_DIGIT);
  assign w_expire = w_tmr_zero | w_tmr_last;
  lock_timer #(.W(TW)) u_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_en       (w_tmr_en),
    .o_zero     (w_tmr_zero),
    .o_last     (w_tmr_last)
  );
`ifdef LOCK_PROG_EN
  logic [DIGIT_W-1:0] r_combo [NUM_DIGITS];
  logic [DIGIT_W-1:0] r_shadow [NUM_DIGITS];
  logic               w_commit, w_shadow_clr, w_shadow_we;
  // shadow collects a program pass; the commit folds in the final digit so OPEN follows at once
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n)
      for (int i = 0; i < NUM_DIGITS; i++) begin
        r_combo[i]  <= default_digit(i);
        r_shadow[i] <= '0;
      end
    else
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (w_shadow_clr) r_shadow[i] <= '0;
        else if (w_shadow_we && r_pos == PW'(i)) r_shadow[i] <= i_digit;
        if (w_commit) r_combo[i] <= (r_pos == PW'(i)) ? i_digit : r_shadow[i];
      end
  assign w_combo = r_combo;
`else
  for (genvar g = 0; g < NUM_DIGITS; g++) assign w_combo[g] = default_digit(g);
`endif
  // state, position, mismatch flag and failure count registers
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state <= S_ENTRY;
      r_pos   <= '0;
      r_mis   <= 1'b0;
      r_fail  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pos   <= w_pos_nxt;
      r_mis   <= w_mis_nxt;
      r_fail  <= w_fail_nxt;
    end
  // next-state, counters and timer control
  always_comb begin
    w_state_nxt = r_state;
    w_pos_nxt   = r_pos;
    w_mis_nxt   = r_mis;
    w_fail_nxt  = r_fail;
    w_load      = 1'b0;
    w_load_val  = T_IDLE;
    w_tmr_en    = 1'b0;
`ifdef LOCK_PROG_EN
    w_commit     = 1'b0;
    w_shadow_clr = 1'b0;
    w_shadow_we  = 1'b0;
`endif
    case (r_state)
      S_ENTRY: begin
        w_tmr_en = (r_pos != '0);
        if (w_xfer) begin
          w_load    = 1'b1;
          w_mis_nxt = r_mis | ~w_hit;
          w_pos_nxt = r_pos + 1'b1;
          if (r_pos == LAST_POS) begin
            w_state_nxt = (!r_mis && w_hit) ? S_OPEN : S_FAIL;
            w_fail_nxt  = (!r_mis && w_hit) ? '0 : r_fail;
            w_pos_nxt   = '0;
            w_mis_nxt   = 1'b0;
          end
        end else if (w_tmr_en && w_expire) begin
          w_pos_nxt = '0;
          w_mis_nxt = 1'b0;
        end
      end
      S_FAIL: begin
        w_fail_nxt  = (r_fail == FAIL_MAX) ? r_fail : r_fail + 1'b1;
        w_state_nxt = (w_fail_nxt == FAIL_MAX) ? S_LOCKOUT : S_ENTRY;
        w_load      = (w_fail_nxt == FAIL_MAX);
        w_load_val  = T_LOCK;
      end
      S_LOCKOUT: begin
        w_tmr_en = 1'b1;
        if (w_expire) begin
          w_state_nxt = S_ENTRY;
          w_fail_nxt  = '0;
        end
      end
      S_OPEN: begin
        if (i_relock) w_state_nxt = S_ENTRY;
`ifdef LOCK_PROG_EN
        else if (i_prog_req) begin
          w_state_nxt  = S_PROG;
          w_pos_nxt    = '0;
          w_shadow_clr = 1'b1;
          w_load       = 1'b1;
        end
`endif
      end
`ifdef LOCK_PROG_EN
      S_PROG: begin
        w_tmr_en = 1'b1;
        if (w_xfer) begin
          w_load = 1'b1;
          if (i_digit <= MAX_DIGIT) begin
            w_shadow_we = 1'b1;
            w_pos_nxt   = r_pos + 1'b1;
            if (r_pos == LAST_POS) begin
              w_commit    = 1'b1;
              w_pos_nxt   = '0;
              w_state_nxt = S_OPEN;
            end
          end
        end else if (w_expire) begin
          w_state_nxt = S_OPEN;
          w_pos_nxt   = '0;
        end
      end
`endif
      default: w_state_nxt = S_ENTRY;
    endcase
  end
  assign o_digit_ready = (r_state == S_ENTRY) || (r_state == S_PROG);
  assign o_open        = (r_state == S_OPEN) || (r_state == S_PROG);
  assign o_locked_out  = (r_state == S_LOCKOUT);
  assign o_fail_cnt    = r_fail;
  assign o_pos         = r_pos;
  assign o_status      = r_state;
endmodule

// File: tb/tb_lock_seq_ctrl.sv
// tb_lock_seq_ctrl: directed and randomized checks of lock_seq_ctrl against a queue-based model
module tb_lock_seq_ctrl;
  localparam int ND = 6, MF = 3, LC = 20, TO = 10;
`ifdef LOCK_PROG_EN
  localparam bit PROG = 1'b1;
`else
  localparam bit PROG = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, valid = 1'b0, relock = 1'b0, prog_req = 1'b0;
  logic [3:0] digit = 4'd0;
  logic ready, open_o, locked;
  logic [1:0] fail_cnt;
  logic [2:0] pos, status;
  int n_chk = 0, n_pass = 0;
  int def_c[ND] = '{8, 7, 5, 8, 2, 8};
  int bad_c[ND] = '{8, 7, 0, 8, 2, 8};
  int new_c[ND] = '{1, 2, 3, 4, 5, 6};
  always #5 clk = ~clk;
  lock_seq_ctrl #(
    .NUM_DIGITS(ND), .MAX_FAIL(MF), .LOCKOUT_CYCLES(LC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_digit(digit), .i_digit_valid(valid),
    .o_digit_ready(ready), .i_relock(relock),
`ifdef LOCK_PROG_EN
    .i_prog_req(prog_req),
`endif
    .o_open(open_o), .o_locked_out(locked), .o_fail_cnt(fail_cnt), .o_pos(pos), .o_status(status)
  );
  int m_st, m_fail, m_left, m_idle;
  int m_combo[ND];
  int m_entry[$], m_shadow[$];
  function automatic bit m_ready();
    return m_st == 0 || m_st == 4;
  endfunction
  function automatic int m_pos();
    return m_st == 4 ? m_shadow.size() : (m_st == 0 ? m_entry.size() : 0);
  endfunction
  task automatic m_reset();
    m_st = 0; m_fail = 0; m_left = 0; m_idle = 0;
    m_entry.delete(); m_shadow.delete();
    m_combo = '{8, 7, 5, 8, 2, 8};
  endtask
  task automatic m_step();
    bit x, ok;
    x = valid && m_ready();
    case (m_st)
      0: if (x) begin
        m_entry.push_back(int'(digit));
        m_idle = 0;
        if (m_entry.size() == ND) begin
          ok = 1'b1;
          for (int i = 0; i < ND; i++) if (m_entry[i] != m_combo[i]) ok = 1'b0;
          m_st = ok ? 1 : 2;
          if (ok) m_fail = 0;
          m_entry.delete();
        end
      end else if (m_entry.size() > 0) begin
        m_idle++;
        if (m_idle == TO) m_entry.delete();
      end
      1: if (relock) m_st = 0;
         else if (PROG && prog_req) begin m_st = 4; m_shadow.delete(); m_idle = 0; end
      2: begin
        m_fail = (m_fail < MF) ? m_fail + 1 : MF;
        if (m_fail == MF) begin m_st = 3; m_left = LC; end
        else m_st = 0;
      end
      3: begin
        m_left--;
        if (m_left == 0) begin m_st = 0; m_fail = 0; end
      end
      4: if (x) begin
        m_idle = 0;
        if (digit <= 4'd9) begin
          m_shadow.push_back(int'(digit));
          if (m_shadow.size() == ND) begin
            for (int i = 0; i < ND; i++) m_combo[i] = m_shadow[i];
            m_st = 1;
          end
        end
      end else begin
        m_idle++;
        if (m_idle == TO) m_st = 1;
      end
      default: m_st = 0;
    endcase
  endtask
  always @(posedge clk or negedge rst_n)
    if (!rst_n) m_reset();
    else m_step();
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask
  always @(negedge clk)
    if (rst_n) begin
      chk("m_ready", int'(ready), int'(m_ready()));
      chk("m_open", int'(open_o), int'(m_st == 1 || m_st == 4));
      chk("m_locked", int'(locked), int'(m_st == 3));
      chk("m_fail_cnt", int'(fail_cnt), m_fail);
      chk("m_pos", int'(pos), m_pos());
      chk("m_status", int'(status), m_st);
    end
  task automatic enter(input int s[ND], input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      digit = 4'(s[i]);
      valid = 1'b1;
    end
    @(negedge clk);
    valid = 1'b0;
  endtask
  task automatic pulse_relock();
    @(negedge clk); relock = 1'b1;
    @(negedge clk); relock = 1'b0;
  endtask
  task automatic pulse_prog();
    @(negedge clk); prog_req = 1'b1;
    @(negedge clk); prog_req = 1'b0;
  endtask
  initial begin
    int cnt, p;
    m_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_status", int'(status), 0);
    chk("rst_ready", int'(ready), 1);
    chk("rst_open", int'(open_o), 0);
    chk("rst_fail", int'(fail_cnt), 0);
    enter(def_c, ND);
    chk("combo_open", int'(open_o), 1);
    chk("combo_status", int'(status), 1);
    pulse_relock();
    chk("relock_ready", int'(ready), 1);
    chk("relock_open", int'(open_o), 0);
    enter(bad_c, ND);
    chk("wrong_status_fail", int'(status), 2);
    @(negedge clk);
    chk("wrong_back_entry", int'(status), 0);
    chk("wrong_fail_cnt", int'(fail_cnt), 1);
    enter(bad_c, ND);
    @(negedge clk);
    enter(bad_c, ND);
    cnt = 0;
    for (int k = 0; k < 10 * LC; k++) begin
      @(negedge clk);
      if (!locked) break;
      cnt++;
    end
    chk("lockout_len", cnt, LC);
    chk("lockout_ready_back", int'(ready), 1);
    chk("lockout_fail_clr", int'(fail_cnt), 0);
    enter(bad_c, ND);
    @(negedge clk);
    enter(def_c, 3);
    repeat (TO - 1) @(negedge clk);
    chk("timeout_pos_held", int'(pos), 3);
    @(negedge clk);
    chk("timeout_pos_clr", int'(pos), 0);
    chk("timeout_fail_kept", int'(fail_cnt), 1);
    enter(def_c, ND);
    chk("after_timeout_open", int'(open_o), 1);
    chk("after_timeout_fail", int'(fail_cnt), 0);
`ifdef LOCK_PROG_EN
    pulse_prog();
    chk("prog_status", int'(status), 4);
    enter(new_c, ND);
    chk("prog_commit", int'(status), 1);
    pulse_relock();
    enter(new_c, ND);
    chk("new_combo_open", int'(open_o), 1);
    pulse_relock();
    enter(def_c, ND);
    chk("old_combo_fail", int'(status), 2);
    @(negedge clk);
    enter(new_c, ND);
    pulse_prog();
    enter(new_c, 4);
`else
    pulse_relock();
    enter(def_c, 4);
`endif
    rst_n = 1'b0;
    #1;
    chk("rst_mid_open", int'(open_o), 0);
    chk("rst_mid_status", int'(status), 0);
    chk("rst_mid_pos", int'(pos), 0);
    @(negedge clk);
    rst_n = 1'b1;
    enter(def_c, ND);
    chk("default_restored", int'(open_o), 1);
    pulse_relock();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      p = m_pos();
      valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) != 0 && p < ND)
        digit = 4'(m_st == 4 ? int'($urandom_range(0, 9)) : m_combo[p]);
      else
        digit = 4'($urandom_range(0, 15));
      relock = ($urandom_range(0, 15) == 0);
      prog_req = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 63) == 0) begin
        valid = 1'b0;
        repeat (TO + 1) @(negedge clk);
      end
    end
    valid = 1'b0; relock = 1'b0; prog_req = 1'b0;
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/lock_seq_ctrl.md
# lock_seq_ctrl

Sequencing controller for the keypad combination lock. Accepts one BCD digit per valid/ready handshake from the keypad front end and compares it against a stored NUM_DIGITS-digit combination. Counts failed attempts, enforces a timed lockout, and optionally lets the user reprogram the combination while the lock is open. Outputs feed the lock actuator and the 7-segment status display.

## Interface
- NUM_DIGITS, 6: digits per combination.
- MAX_FAIL, 3: consecutive failed attempts that trigger lockout; must be ≥1.
- LOCKOUT_CYCLES, 1000: lockout duration in clk cycles; must be ≥1.
- TIMEOUT_CYCLES, 500: idle cycles allowed between digits before a partial entry is aborted; must be ≥1.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- digit  in  4  keypad digit; only 0–9 are valid.
- digit_valid  in  1  the keypad presents `digit`.
- digit_ready  out  1  the controller can accept a digit; a transfer occurs when valid & ready at a rising edge.
- relock  in  1  level input; closes the lock from OPEN.
- prog_req  in  1  requests reprogramming from OPEN. Present only with LOCK_PROG_EN.
- open  out  1  actuator drive; high only in OPEN and PROG.
- locked_out  out  1  high in LOCKOUT.
- fail_cnt  out  $clog2(MAX_FAIL+1)  consecutive failed attempts.
- pos  out  $clog2(NUM_DIGITS+1)  number of digits accepted in the current entry or program pass.
- status  out  3  display code: 0 ENTRY, 1 OPEN, 2 FAIL, 3 LOCKOUT, 4 PROG.

## Operation
- States: ENTRY, FAIL, LOCKOUT, OPEN, PROG (PROG exists only with the macro).
- Reset values: state ENTRY, pos 0, fail_cnt 0, mismatch flag 0, timer 0, combination = DEFAULT_COMBO (8,7,5,8,2,8). Outputs: digit_ready 1, open 0, locked_out 0, status 0.
- ENTRY:
  - digit_ready is 1.
  - Each transfer compares `digit` against combo[pos]. A mismatch, or any digit >9, sets a sticky mismatch flag. pos then increments.
  - Entry always continues to NUM_DIGITS digits so an early error is not revealed.
  - On the transfer that makes pos == NUM_DIGITS:
    - mismatch == 0 and the final digit matches → OPEN.
    - Otherwise → FAIL.
    - In both cases pos and the mismatch flag clear.
- FAIL (one cycle):
  - fail_cnt increments.
  - If the new value equals MAX_FAIL → LOCKOUT and the timer loads LOCKOUT_CYCLES. Otherwise → ENTRY.
- LOCKOUT:
  - digit_ready is 0.
  - The timer decrements every cycle. When it reaches 0 → ENTRY with fail_cnt cleared.
- OPEN:
  - fail_cnt clears on entry. digit_ready is 0.
  - relock → ENTRY.
  - prog_req → PROG, with pos 0 and the shadow combination cleared.
  - relock and prog_req in the same cycle: relock wins.
- PROG:
  - digit_ready is 1.
  - A transfer of a digit 0–9 writes shadow[pos] and increments pos.
  - A digit >9 is consumed with no write and no pos change.
  - When pos reaches NUM_DIGITS, the shadow register commits to the combination in one cycle → OPEN.
- Entry timeout:
  - Applies in ENTRY with pos > 0, and in PROG.
  - The timer reloads TIMEOUT_CYCLES on every transfer and counts down otherwise.
  - At 0: ENTRY clears pos and mismatch and does not count a failure. PROG discards the shadow register and returns to OPEN.
- Reset asserted mid-operation (entry, lockout or programming) aborts it immediately. The combination reverts to default.

## Timing
- A transfer occurs only at a rising edge with digit_valid & digit_ready. The keypad holds `digit` stable while valid is high and ready is low.
- All outputs are registered or decoded from state only. There are no combinational input→output paths.
- Correct final digit accepted at edge N: open = 1 from edge N onward.
- Wrong final digit at edge N: status = FAIL for cycle N..N+1. At edge N+1, fail_cnt has incremented and the next state (ENTRY or LOCKOUT) is visible.
- LOCKOUT lasts exactly LOCKOUT_CYCLES cycles. digit_ready returns to 1 on the following edge.
- relock sampled at edge N: open = 0 and digit_ready = 1 from edge N.
- fail_cnt saturates at MAX_FAIL; it never wraps.

## Configuration
- LOCK_PROG_EN defined:
  - PROG state, the prog_req port and the shadow register exist.
  - The combination is a writable register.
- LOCK_PROG_EN undefined:
  - No prog_req port.
  - The combination is the constant DEFAULT_COMBO.
  - OPEN exits only via relock.
  - Status code 4 is never produced.

## Structure
- Package lock_pkg holds:
  - the state enum;
  - status codes;
  - DIGIT_W = 4;
  - DEFAULT_COMBO as an array of NUM_DIGITS 4-bit constants.
- Sub-module lock_timer: a loadable down-counter with a zero flag, shared by the lockout and entry-timeout functions. Width is $clog2(max(LOCKOUT_CYCLES, TIMEOUT_CYCLES)+1).

## Test plan
- After reset, enter 8,7,5,8,2,8 back-to-back → open = 1 and status = 1 at the 6th accept edge; fail_cnt = 0.
- Enter 8,7,0,8,2,8 → all 6 digits accepted. status = 2 for one cycle, then 0; fail_cnt = 1; open stays 0.
- Three wrong entries → locked_out = 1 and digit_ready = 0 for exactly LOCKOUT_CYCLES cycles. Then fail_cnt = 0 and ENTRY resumes.
- Enter 8,7,5, then idle for TIMEOUT_CYCLES → pos returns to 0 and fail_cnt is unchanged. A full correct entry then opens the lock.
- With LOCK_PROG_EN: open the lock, pulse prog_req, enter 1,2,3,4,5,6, then relock. Entering 1,2,3,4,5,6 opens; entering 8,7,5,8,2,8 fails.
- Assert reset after the 4th digit of a PROG pass → the combination reverts to default, state ENTRY, open = 0.
